// File: rtl/lookup_cfg_writer_pkg.sv
// Shared constants for the lookup stage config path.
// Header layout, type codes, geometry and writer FSM states.
package lookup_cfg_writer_pkg;

   localparam logic [2:0] CFG_TYPE_CAM = 3'd0;
   localparam logic [2:0] CFG_TYPE_ACT = 3'd1;

   localparam int HDR_STAGE_LSB = 0;
   localparam int HDR_STAGE_W   = 5;
   localparam int HDR_TYPE_LSB  = 5;
   localparam int HDR_TYPE_W    = 3;
   localparam int HDR_IDX_LSB   = 8;
   localparam int HDR_IDX_W     = 4;

   localparam int LKP_KEY_W  = 1024;
   localparam int LKP_ACT_W  = 25;
   localparam int LKP_ADDR_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAM_DATA,
      ST_CAM_MASK,
      ST_ACT_DATA,
      ST_WRITE,
      ST_DRAIN
   } cfg_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/lookup_cfg_writer.sv
// Config-stream writer for one lookup stage.
// Assembles TCAM entry/mask or action word and strobes it out.
module lookup_cfg_writer
   import lookup_cfg_writer_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = 256,
   parameter int KEY_W               = LKP_KEY_W,
   parameter int ACT_W               = LKP_ACT_W,
   parameter int ADDR_W              = LKP_ADDR_W,
   parameter int STAGE               = 0
) (
   input  logic                           axis_clk,
   input  logic                           aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                           s_axis_tvalid,
   input  logic                           s_axis_tlast,
   output logic                           s_axis_tready,
   output logic [KEY_W-1:0]               lookup_din,
   output logic [KEY_W-1:0]               lookup_din_mask,
   output logic [ADDR_W-1:0]              lookup_din_addr,
   output logic                           lookup_din_en,
   output logic [ACT_W-1:0]               action_data_in,
   output logic [ADDR_W-1:0]              action_addr,
   output logic                           action_en,
   output logic [15:0]                    err_cnt
);

   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int NB    = KEY_W / DW;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NB - 1);
   localparam logic [4:0]       STAGE_ID = 5'(STAGE);

   cfg_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] idx_r;
   logic              last_r;
   logic [KEY_W-1:0]  din_asm;
   logic [KEY_W-1:0]  mask_asm;
   logic [KEY_W-1:0]  din_nxt;
   logic [KEY_W-1:0]  mask_nxt;

   logic [4:0]        hdr_stage;
   logic [2:0]        hdr_type;
   logic [ADDR_W-1:0] hdr_idx;
   logic              beat;
   logic              hdr_known;
   logic              unused_bits;

   assign hdr_stage = s_axis_tdata[HDR_STAGE_LSB +: HDR_STAGE_W];
   assign hdr_type  = s_axis_tdata[HDR_TYPE_LSB +: HDR_TYPE_W];
   assign hdr_idx   = s_axis_tdata[HDR_IDX_LSB +: ADDR_W];
   assign beat      = s_axis_tvalid & s_axis_tready;
   assign hdr_known = (hdr_type == CFG_TYPE_CAM) |
                      (hdr_type == CFG_TYPE_ACT);

   assign unused_bits = ^s_axis_tdata;

   // Beat k lands in slice k; no shifting so aborted packets leave stale slices.
   always_comb begin
      din_nxt  = din_asm;
      mask_nxt = mask_asm;
      for (int k = 0; k < NB; k++) begin
         if (cnt == CNT_W'(k)) begin
            din_nxt[k*DW +: DW]  = s_axis_tdata;
            mask_nxt[k*DW +: DW] = s_axis_tdata;
         end
      end
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         idx_r           <= '0;
         last_r          <= 1'b0;
         din_asm         <= '0;
         mask_asm        <= '0;
         s_axis_tready   <= 1'b0;
         lookup_din      <= '0;
         lookup_din_mask <= '0;
         lookup_din_addr <= '0;
         lookup_din_en   <= 1'b0;
         action_data_in  <= '0;
         action_addr     <= '0;
         action_en       <= 1'b0;
         err_cnt         <= '0;
      end else begin
         lookup_din_en <= 1'b0;
         action_en     <= 1'b0;
         s_axis_tready <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (beat) begin
                  idx_r <= hdr_idx;
                  cnt   <= '0;
                  if (hdr_stage != STAGE_ID) begin
                     state <= s_axis_tlast ? ST_IDLE : ST_DRAIN;
                  end else if (!hdr_known) begin
                     err_cnt <= sat_inc16(err_cnt);
                     state   <= s_axis_tlast ? ST_IDLE : ST_DRAIN;
                  end else if (s_axis_tlast) begin
                     err_cnt <= sat_inc16(err_cnt);
                     state   <= ST_IDLE;
                  end else if (hdr_type == CFG_TYPE_CAM) begin
                     state <= ST_CAM_DATA;
                  end else begin
                     state <= ST_ACT_DATA;
                  end
               end
            end
            ST_CAM_DATA: begin
               if (beat) begin
                  din_asm <= din_nxt;
                  if (s_axis_tlast) begin
                     err_cnt <= sat_inc16(err_cnt);
                     state   <= ST_IDLE;
                  end else if (cnt == CNT_MAX) begin
                     cnt   <= '0;
                     state <= ST_CAM_MASK;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            ST_CAM_MASK: begin
               if (beat) begin
                  mask_asm <= mask_nxt;
                  if (cnt == CNT_MAX) begin
                     cnt             <= '0;
                     lookup_din      <= din_asm;
                     lookup_din_mask <= mask_nxt;
                     lookup_din_addr <= idx_r;
                     lookup_din_en   <= 1'b1;
                     last_r          <= s_axis_tlast;
                     s_axis_tready   <= 1'b0;
                     state           <= ST_WRITE;
                  end else if (s_axis_tlast) begin
                     err_cnt <= sat_inc16(err_cnt);
                     state   <= ST_IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            ST_ACT_DATA: begin
               if (beat) begin
                  action_data_in <= s_axis_tdata[ACT_W-1:0];
                  action_addr    <= idx_r;
                  action_en      <= 1'b1;
                  last_r         <= s_axis_tlast;
                  s_axis_tready  <= 1'b0;
                  state          <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // Packet longer than its type allows: flag it, swallow the rest.
               if (last_r) begin
                  state <= ST_IDLE;
               end else begin
                  err_cnt <= sat_inc16(err_cnt);
                  state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (beat && s_axis_tlast) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
